// File: rtl/mgmt_bus_arbiter.sv
// Round-robin arbiter sharing the 16-bit addr / 8-bit data register bus between NUM_MASTERS masters,
// one buffered op per master. Request to bus pulse is 2 cycles; a busy master's new requests are dropped.
module mgmt_bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int RD_TIMEOUT  = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_MASTERS-1:0]     m_rd_en_i,
    input  logic [16*NUM_MASTERS-1:0]  m_rd_addr_i,
    input  logic [NUM_MASTERS-1:0]     m_wr_en_i,
    input  logic [16*NUM_MASTERS-1:0]  m_wr_addr_i,
    input  logic [8*NUM_MASTERS-1:0]   m_wr_data_i,
    output logic [NUM_MASTERS-1:0]     m_busy_o,
    output logic [NUM_MASTERS-1:0]     m_rd_valid_o,
    output logic [NUM_MASTERS-1:0]     m_rd_timeout_o,
    output logic [7:0]                 m_rd_data_o,
    output logic                       rd_en_o,
    output logic [15:0]                rd_addr_o,
    input  logic                       rd_valid_i,
    input  logic [7:0]                 rd_data_i,
    output logic                       wr_en_o,
    output logic [15:0]                wr_addr_o,
    output logic [7:0]                 wr_data_o
);
    localparam int PW = $clog2(NUM_MASTERS);
    localparam int CW = $clog2(RD_TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam logic [PW-1:0] LAST_IDX = PW'(NUM_MASTERS - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(RD_TIMEOUT);

    logic [1:0]                   state_q, state_d;
    logic [PW-1:0]                gnt_q, gnt_d;
    logic [PW-1:0]                rr_q, rr_d, rr_next;
    logic [CW-1:0]                cnt_q, cnt_d, cnt_inc;
    logic [NUM_MASTERS-1:0]       pend_q, pend_d;
    logic [NUM_MASTERS-1:0]       op_wr_q, op_wr_d;
    logic [NUM_MASTERS-1:0][15:0] addr_q, addr_d;
    logic [NUM_MASTERS-1:0][7:0]  data_q, data_d;

    logic                         rd_en_q, rd_en_d;
    logic                         wr_en_q, wr_en_d;
    logic [15:0]                  rd_addr_q, rd_addr_d;
    logic [15:0]                  wr_addr_q, wr_addr_d;
    logic [7:0]                   wr_data_q, wr_data_d;
    logic [7:0]                   m_rd_data_q, m_rd_data_d;
    logic [NUM_MASTERS-1:0]       m_rd_valid_q, m_rd_valid_d;
    logic [NUM_MASTERS-1:0]       m_rd_timeout_q, m_rd_timeout_d;

    logic                         gnt_found;
    logic [PW-1:0]                gnt_idx;
    logic [PW-1:0]                cand;
    int                           idx;

    // Scan downward so the last hit is the first pending slot at or after rr_q.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        idx       = 0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_MASTERS) begin
                idx = idx - NUM_MASTERS;
            end
            cand = PW'(idx);
            if (pend_q[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign rr_next = (gnt_q == LAST_IDX) ? '0 : gnt_q + PW'(1);
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d        = state_q;
        gnt_d          = gnt_q;
        rr_d           = rr_q;
        cnt_d          = cnt_q;
        pend_d         = pend_q;
        op_wr_d        = op_wr_q;
        addr_d         = addr_q;
        data_d         = data_q;
        rd_en_d        = 1'b0;
        wr_en_d        = 1'b0;
        rd_addr_d      = rd_addr_q;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        m_rd_data_d    = m_rd_data_q;
        m_rd_valid_d   = '0;
        m_rd_timeout_d = '0;

        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    gnt_d   = gnt_idx;
                    state_d = S_ISSUE;
                    if (op_wr_q[gnt_idx]) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q[gnt_idx];
                        wr_data_d = data_q[gnt_idx];
                    end else begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = addr_q[gnt_idx];
                    end
                end
            end
            S_ISSUE: begin
                if (op_wr_q[gnt_q]) begin
                    pend_d[gnt_q] = 1'b0;
                    rr_d          = rr_next;
                    state_d       = S_IDLE;
                end else begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                // Data arriving on the expiry cycle still counts as a normal completion.
                if (rd_valid_i) begin
                    m_rd_valid_d[gnt_q] = 1'b1;
                    m_rd_data_d         = rd_data_i;
                    pend_d[gnt_q]       = 1'b0;
                    rr_d                = rr_next;
                    state_d             = S_IDLE;
                end else if (cnt_inc == CNT_MAX) begin
                    m_rd_valid_d[gnt_q]   = 1'b1;
                    m_rd_timeout_d[gnt_q] = 1'b1;
                    m_rd_data_d           = 8'h00;
                    pend_d[gnt_q]         = 1'b0;
                    rr_d                  = rr_next;
                    state_d               = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Capture looks only at registered busy, so a slot freed this cycle cannot be refilled until next cycle.
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!pend_q[i]) begin
                if (m_wr_en_i[i]) begin
                    pend_d[i]  = 1'b1;
                    op_wr_d[i] = 1'b1;
                    addr_d[i]  = m_wr_addr_i[16*i +: 16];
                    data_d[i]  = m_wr_data_i[8*i +: 8];
                end else if (m_rd_en_i[i]) begin
                    pend_d[i]  = 1'b1;
                    op_wr_d[i] = 1'b0;
                    addr_d[i]  = m_rd_addr_i[16*i +: 16];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            gnt_q          <= '0;
            rr_q           <= '0;
            cnt_q          <= '0;
            pend_q         <= '0;
            op_wr_q        <= '0;
            addr_q         <= '0;
            data_q         <= '0;
            rd_en_q        <= 1'b0;
            wr_en_q        <= 1'b0;
            rd_addr_q      <= '0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            m_rd_data_q    <= '0;
            m_rd_valid_q   <= '0;
            m_rd_timeout_q <= '0;
        end else begin
            state_q        <= state_d;
            gnt_q          <= gnt_d;
            rr_q           <= rr_d;
            cnt_q          <= cnt_d;
            pend_q         <= pend_d;
            op_wr_q        <= op_wr_d;
            addr_q         <= addr_d;
            data_q         <= data_d;
            rd_en_q        <= rd_en_d;
            wr_en_q        <= wr_en_d;
            rd_addr_q      <= rd_addr_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            m_rd_data_q    <= m_rd_data_d;
            m_rd_valid_q   <= m_rd_valid_d;
            m_rd_timeout_q <= m_rd_timeout_d;
        end
    end

    assign m_busy_o       = pend_q;
    assign m_rd_valid_o   = m_rd_valid_q;
    assign m_rd_timeout_o = m_rd_timeout_q;
    assign m_rd_data_o    = m_rd_data_q;
    assign rd_en_o        = rd_en_q;
    assign rd_addr_o      = rd_addr_q;
    assign wr_en_o        = wr_en_q;
    assign wr_addr_o      = wr_addr_q;
    assign wr_data_o      = wr_data_q;

endmodule

// File: tb/tb_mgmt_bus_arbiter.sv
// Bench for mgmt_bus_arbiter: directed scenarios plus random traffic against a transaction-timed reference model.
module tb_mgmt_bus_arbiter;
    localparam int NM = 3;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NM-1:0]   m_rd_en, m_wr_en;
    logic [16*NM-1:0] m_rd_addr, m_wr_addr;
    logic [8*NM-1:0] m_wr_data;
    logic [NM-1:0]   m_busy_o, m_rd_valid_o, m_rd_timeout_o;
    logic [7:0]      m_rd_data_o;
    logic            rd_en_o, wr_en_o, rd_valid;
    logic [15:0]     rd_addr_o, wr_addr_o;
    logic [7:0]      rd_data, wr_data_o;

    mgmt_bus_arbiter #(.NUM_MASTERS(NM), .RD_TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .m_rd_en_i      (m_rd_en),
        .m_rd_addr_i    (m_rd_addr),
        .m_wr_en_i      (m_wr_en),
        .m_wr_addr_i    (m_wr_addr),
        .m_wr_data_i    (m_wr_data),
        .m_busy_o       (m_busy_o),
        .m_rd_valid_o   (m_rd_valid_o),
        .m_rd_timeout_o (m_rd_timeout_o),
        .m_rd_data_o    (m_rd_data_o),
        .rd_en_o        (rd_en_o),
        .rd_addr_o      (rd_addr_o),
        .rd_valid_i     (rd_valid),
        .rd_data_i      (rd_data),
        .wr_en_o        (wr_en_o),
        .wr_addr_o      (wr_addr_o),
        .wr_data_o      (wr_data_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_rd_pulse = 0;
    int n_wr_pulse = 0;
    logic [15:0] wr_log[$];

    // Reference model: slots, rotation pointer, current owner and the cycle its bus pulse appears.
    bit [NM-1:0]  md_pend, md_wr;
    logic [15:0]  md_addr[NM];
    logic [7:0]   md_data[NM];
    int           md_rr, md_owner, md_pulse;
    logic         e_rd_en, e_wr_en;
    logic [15:0]  e_rd_addr, e_wr_addr;
    logic [7:0]   e_wr_data, e_mrd;
    logic [NM-1:0] e_mrv, e_mrt, e_busy;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        md_pend = '0; md_wr = '0; md_rr = 0; md_owner = -1; md_pulse = 0;
        for (int i = 0; i < NM; i++) begin md_addr[i] = '0; md_data[i] = '0; end
        e_rd_en = 0; e_wr_en = 0; e_rd_addr = '0; e_wr_addr = '0; e_wr_data = '0;
        e_mrd = '0; e_mrv = '0; e_mrt = '0; e_busy = '0;
    endtask

    task automatic model_finish();
        md_pend[md_owner] = 1'b0;
        md_rr    = (md_owner + 1) % NM;
        md_owner = -1;
    endtask

    task automatic model_edge();
        bit [NM-1:0] p;
        int g;
        if (!rst_n) begin model_reset(); return; end
        p = md_pend;
        e_rd_en = 0; e_wr_en = 0; e_mrv = '0; e_mrt = '0;
        if (md_owner < 0) begin
            for (int k = 0; k < NM; k++) begin
                g = (md_rr + k) % NM;
                if (p[g]) begin md_owner = g; break; end
            end
            if (md_owner >= 0) begin
                md_pulse = cyc + 1;
                if (md_wr[md_owner]) begin
                    e_wr_en = 1; e_wr_addr = md_addr[md_owner]; e_wr_data = md_data[md_owner];
                end else begin
                    e_rd_en = 1; e_rd_addr = md_addr[md_owner];
                end
            end
        end else if (cyc == md_pulse) begin
            if (md_wr[md_owner]) model_finish();
        end else if (rd_valid) begin
            e_mrv[md_owner] = 1'b1; e_mrd = rd_data; model_finish();
        end else if (cyc - md_pulse == TO) begin
            e_mrv[md_owner] = 1'b1; e_mrt[md_owner] = 1'b1; e_mrd = 8'h00; model_finish();
        end
        for (int i = 0; i < NM; i++) begin
            if (!p[i] && m_wr_en[i]) begin
                md_pend[i] = 1; md_wr[i] = 1;
                md_addr[i] = m_wr_addr[16*i +: 16]; md_data[i] = m_wr_data[8*i +: 8];
            end else if (!p[i] && m_rd_en[i]) begin
                md_pend[i] = 1; md_wr[i] = 0; md_addr[i] = m_rd_addr[16*i +: 16];
            end
        end
        e_busy = md_pend;
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, 64'({m_busy_o, m_rd_valid_o, m_rd_timeout_o, m_rd_data_o, rd_en_o, rd_addr_o,
                      wr_en_o, wr_addr_o, wr_data_o}), 64'd0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        if (wr_en_o) wr_log.push_back(wr_addr_o);
        n_rd_pulse += int'(rd_en_o);
        n_wr_pulse += int'(wr_en_o);
        chk("busy", 64'(m_busy_o), 64'(e_busy));
        chk("bus", 64'({rd_en_o, rd_addr_o, wr_en_o, wr_addr_o, wr_data_o}),
                   64'({e_rd_en, e_rd_addr, e_wr_en, e_wr_addr, e_wr_data}));
        chk("cmpl", 64'({m_rd_valid_o, m_rd_timeout_o, m_rd_data_o}), 64'({e_mrv, e_mrt, e_mrd}));
        m_rd_en = '0; m_wr_en = '0; rd_valid = 1'b0;
    endtask

    task automatic req_wr(input int m, input logic [15:0] a, input logic [7:0] d);
        m_wr_en[m] = 1'b1; m_wr_addr[16*m +: 16] = a; m_wr_data[8*m +: 8] = d;
    endtask

    task automatic req_rd(input int m, input logic [15:0] a);
        m_rd_en[m] = 1'b1; m_rd_addr[16*m +: 16] = a;
    endtask

    task automatic wait_rd_en();
        for (int k = 0; k < 12 && !rd_en_o; k++) step();
    endtask

    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_all_zero(tag);
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int lat;
        int rsp_at;
        int l;
        rst_n = 1'b1; m_rd_en = '0; m_wr_en = '0; m_rd_addr = '0; m_wr_addr = '0; m_wr_data = '0;
        rd_valid = 1'b0; rd_data = '0;
        model_reset();
        #1 rst_n = 1'b0;
        #1 chk_all_zero("reset_state");
        step(); step();
        rst_n = 1'b1;

        // 1: single write timing
        req_wr(0, 16'h0010, 8'hA5);
        step();
        chk("t1_busy_T1", 64'(m_busy_o[0]), 64'd1);
        chk("t1_wr_T1", 64'(wr_en_o), 64'd0);
        step();
        chk("t1_wr_T2", 64'({wr_en_o, wr_addr_o, wr_data_o}), 64'({1'b1, 16'h0010, 8'hA5}));
        chk("t1_busy_T2", 64'(m_busy_o[0]), 64'd1);
        step();
        chk("t1_busy_T3", 64'(m_busy_o[0]), 64'd0);
        chk("t1_wr_T3", 64'(wr_en_o), 64'd0);

        // 2: read with data 3 cycles after rd_en
        req_rd(1, 16'h0004);
        wait_rd_en();
        chk("t2_rd_en", 64'({rd_en_o, rd_addr_o}), 64'({1'b1, 16'h0004}));
        step(); step(); step();
        rd_valid = 1'b1; rd_data = 8'h5A;
        step();
        chk("t2_cmpl", 64'({m_rd_valid_o, m_rd_timeout_o, m_rd_data_o}), 64'({3'b010, 3'b000, 8'h5A}));
        chk("t2_busy", 64'(m_busy_o[1]), 64'd0);

        // 3: round-robin order from rr_ptr=0
        pulse_reset("t3_reset");
        wr_log.delete();
        req_wr(0, 16'h0100, 8'h10); req_wr(1, 16'h0101, 8'h11); req_wr(2, 16'h0102, 8'h12);
        repeat (8) step();
        req_wr(0, 16'h0200, 8'h20); req_wr(2, 16'h0202, 8'h22);
        repeat (6) step();
        chk("t3_count", 64'(wr_log.size()), 64'd5);
        chk("t3_order0", 64'(wr_log[0]), 64'h0100);
        chk("t3_order1", 64'(wr_log[1]), 64'h0101);
        chk("t3_order2", 64'(wr_log[2]), 64'h0102);
        chk("t3_order3", 64'(wr_log[3]), 64'h0200);
        chk("t3_order4", 64'(wr_log[4]), 64'h0202);

        // 4: read timeout, then a late rd_valid
        req_rd(0, 16'h0040);
        wait_rd_en();
        chk("t4_rd_en", 64'(rd_en_o), 64'd1);
        lat = 0;
        for (int k = 0; k < 30 && m_rd_valid_o == '0; k++) begin step(); lat++; end
        chk("t4_latency", 64'(lat), 64'd17);
        chk("t4_cmpl", 64'({m_rd_valid_o, m_rd_timeout_o, m_rd_data_o}), 64'({3'b001, 3'b001, 8'h00}));
        repeat (4) step();
        rd_valid = 1'b1; rd_data = 8'h77;
        step();
        chk("t4_late_ignored", 64'(m_rd_valid_o), 64'd0);
        chk("t4_idle_busy", 64'(m_busy_o), 64'd0);

        // 5: simultaneous rd/wr, then request while busy
        n_rd_pulse = 0; n_wr_pulse = 0;
        req_wr(0, 16'h0300, 8'h3C); req_rd(0, 16'h0301);
        step();
        req_rd(0, 16'h0302);
        step();
        req_wr(0, 16'h0303, 8'h33);
        repeat (6) step();
        chk("t5_wr_pulses", 64'(n_wr_pulse), 64'd1);
        chk("t5_rd_pulses", 64'(n_rd_pulse), 64'd0);

        // 6: reset during WAIT
        req_rd(1, 16'h0400);
        wait_rd_en();
        step(); step();
        pulse_reset("t6_reset_now");
        rd_valid = 1'b1; rd_data = 8'h99;
        step();
        chk("t6_stray_ignored", 64'(m_rd_valid_o), 64'd0);
        step();
        req_rd(1, 16'h0401);
        wait_rd_en();
        chk("t6_rd_en", 64'({rd_en_o, rd_addr_o}), 64'({1'b1, 16'h0401}));
        step();
        rd_valid = 1'b1; rd_data = 8'h3C;
        step();
        chk("t6_cmpl", 64'({m_rd_valid_o, m_rd_timeout_o, m_rd_data_o}), 64'({3'b010, 3'b000, 8'h3C}));

        // Random traffic; responder latencies cluster around the timeout boundary.
        rsp_at = -1;
        for (int c = 0; c < 1500; c++) begin
            for (int m = 0; m < NM; m++) begin
                if ($urandom_range(0, 4) == 0) req_wr(m, 16'($urandom), 8'($urandom));
                if ($urandom_range(0, 3) == 0) req_rd(m, 16'($urandom));
            end
            if (rd_en_o) begin
                case ($urandom_range(0, 3))
                    0:       l = $urandom_range(1, 14);
                    1:       l = $urandom_range(15, 17);
                    2:       l = $urandom_range(18, 22);
                    default: l = TO;
                endcase
                rsp_at = cyc + l;
            end
            rd_data = 8'($urandom);
            if (cyc == rsp_at || $urandom_range(0, 40) == 0) rd_valid = 1'b1;
            if ($urandom_range(0, 400) == 0) pulse_reset("rand_reset");
            else step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
